// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler: queues execute/memory writes and serialises them onto one register-file write port.
// Latency: a request accepted into an empty queue at edge k is presented on wr_* after edge k+1; 1 write/cycle.
// Backpressure: in_ready drops when fewer than two slots are free; wr_hold freezes the write port and the dequeue.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   e_valid/e_dst/e_val     execute write request (valE)
//   m_valid/m_dst/m_val     memory write request (valM)
//   in_ready                both request slots can be accepted this cycle
//   wr_hold                 register file stall; holds wr_* and blocks dequeue
//   wr_en/wr_addr/wr_data   registered register-file write port
//   pend_mask               registers with a queued or in-flight write
//   count                   occupied queue entries
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          e_valid,
  input  logic [3:0]    e_dst,
  input  logic [W-1:0]  e_val,
  input  logic          m_valid,
  input  logic [3:0]    m_dst,
  input  logic [W-1:0]  m_val,
  output logic          in_ready,
  input  logic          wr_hold,
  output logic          wr_en,
  output logic [3:0]    wr_addr,
  output logic [W-1:0]  wr_data,
  output logic [14:0]   pend_mask,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]   dst;
    logic [W-1:0] val;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           wr_en_q, wr_en_d;
  logic [3:0]     wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;

  logic           e_keep, m_keep, deq;

  // Admission only needs state, so requesters never see a loop through e_*/m_*.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // RNONE requests are accepted but never take a slot.
    e_keep = e_valid && in_ready && (e_dst != RNONE);
    m_keep = m_valid && in_ready && (m_dst != RNONE);
    deq    = !wr_hold && (count_q != '0);

    // E goes ahead of M so that a same-register pair leaves M's value last.
    if (e_keep) begin
      mem_d[wr_ptr_q] = '{dst: e_dst, val: e_val};
    end
    if (m_keep) begin
      mem_d[e_keep ? (wr_ptr_q + PW'(1)) : wr_ptr_q] = '{dst: m_dst, val: m_val};
    end
    wr_ptr_d = wr_ptr_q + PW'(e_keep) + PW'(m_keep);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(e_keep) + CW'(m_keep) - CW'(deq);

    // Port is frozen under wr_hold; otherwise it shows the head or goes idle,
    // keeping the last address/data when idle.
    if (!wr_hold) begin
      wr_en_d = deq;
      if (deq) begin
        wr_addr_d = mem_q[rd_ptr_q].dst;
        wr_data_d = mem_q[rd_ptr_q].val;
      end
    end
  end

  // Stored entries always carry dst <= 14, so the decode never touches bit 15.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pend_mask = pend_mask | (15'(1) << mem_q[rd_ptr_q + PW'(i)].dst);
      end
    end
    if (wr_en_q) begin
      pend_mask = pend_mask | (15'(1) << wr_addr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= RNONE;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int W     = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          e_valid, m_valid;
  logic [3:0]    e_dst, m_dst;
  logic [W-1:0]  e_val, m_val;
  logic          in_ready;
  logic          wr_hold;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [14:0]   pend_mask;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .e_valid(e_valid), .e_dst(e_dst), .e_val(e_val),
    .m_valid(m_valid), .m_dst(m_dst), .m_val(m_val),
    .in_ready(in_ready), .wr_hold(wr_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_mask(pend_mask), .count(count)
  );

  typedef struct packed {
    logic [3:0]   a;
    logic [W-1:0] d;
  } wr_t;

  wr_t          sb[$];
  logic [W-1:0] rf [16];
  int           checks = 0;
  int           passes = 0;
  int           fails  = 0;
  int           nwrites = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request cycle; record what the arbiter must accept.
  task automatic issue(input logic ev, input logic [3:0] ed, input logic [W-1:0] evl,
                       input logic mv, input logic [3:0] md, input logic [W-1:0] mvl);
    e_valid = ev; e_dst = ed; e_val = evl;
    m_valid = mv; m_dst = md; m_val = mvl;
    if (in_ready) begin
      if (ev && ed != 4'hF) sb.push_back('{a: ed, d: evl});
      if (mv && md != 4'hF) sb.push_back('{a: md, d: mvl});
    end
    tick();
    e_valid = 1'b0;
    m_valid = 1'b0;
  endtask

  function automatic logic [14:0] model_pend();
    logic [14:0] m;
    m = '0;
    foreach (sb[i]) m = m | (15'(1) << sb[i].a);
    return m;
  endfunction

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !wr_en && count == '0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  // Register-file side: a write is performed at the edge following a cycle
  // with wr_en=1 and wr_hold=0, unless that edge is a reset edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1 && wr_hold === 1'b0) begin
      nwrites++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(sb.size()), 64'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr_order", 64'(wr_addr), 64'(e.a));
        chk("wr_data_order", 64'(wr_data), 64'(e.d));
      end
      rf[wr_addr] = wr_data;
    end
  end

  initial begin
    int n0;
    rst_n = 1'b0; wr_hold = 1'b0;
    e_valid = 1'b0; e_dst = '0; e_val = '0;
    m_valid = 1'b0; m_dst = '0; m_val = '0;
    foreach (rf[i]) rf[i] = '0;

    // Reset
    tick(); tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_addr", 64'(wr_addr), 64'hF);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single write: accepted at edge k
    issue(1'b1, 4'd0, 64'd111, 1'b0, 4'd0, 64'd0);
    chk("single_count_k", 64'(count), 64'd1);
    chk("single_pend_k", 64'(pend_mask), 64'h0001);
    chk("single_wr_en_k", 64'(wr_en), 64'd0);
    tick();
    chk("single_wr_en_k1", 64'(wr_en), 64'd1);
    chk("single_wr_addr_k1", 64'(wr_addr), 64'd0);
    chk("single_wr_data_k1", 64'(wr_data), 64'd111);
    chk("single_pend_k1", 64'(pend_mask), 64'h0001);
    tick();
    chk("single_pend_k2", 64'(pend_mask), 64'd0);
    chk("single_wr_en_k2", 64'(wr_en), 64'd0);
    chk("idle_keeps_addr", 64'(wr_addr), 64'd0);
    chk("idle_keeps_data", 64'(wr_data), 64'd111);
    chk("single_rf0", 64'(rf[0]), 64'd111);

    // popq pair on the same register: M's value must land last
    n0 = nwrites;
    issue(1'b1, 4'd4, 64'd563, 1'b1, 4'd4, 64'd42);
    chk("popq_count", 64'(count), 64'd2);
    chk("popq_pend", 64'(pend_mask), 64'h0010);
    wait_drain("popq_drain");
    chk("popq_nwrites", 64'(nwrites - n0), 64'd2);
    chk("popq_rf4", 64'(rf[4]), 64'd42);

    // RNONE request is accepted and dropped
    n0 = nwrites;
    issue(1'b1, 4'hF, 64'd999, 1'b1, 4'd3, 64'd444);
    chk("rnone_count", 64'(count), 64'd1);
    wait_drain("rnone_drain");
    chk("rnone_nwrites", 64'(nwrites - n0), 64'd1);
    chk("rnone_rf3", 64'(rf[3]), 64'd444);

    // Backpressure: fill under wr_hold
    wr_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) break;
      issue(1'b1, 4'(2 * i), 64'(1000 + i), 1'b1, 4'(2 * i + 1), 64'(2000 + i));
    end
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_wr_en", 64'(wr_en), 64'd0);
    issue(1'b1, 4'd9, 64'd77, 1'b0, 4'd0, 64'd0);
    chk("full_ignored_count", 64'(count), 64'(DEPTH));
    chk("full_pend", 64'(pend_mask), 64'(model_pend()));
    wr_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_stream_wr_en", 64'(wr_en), 64'd1);
    end
    tick();
    chk("drain_end_wr_en", 64'(wr_en), 64'd0);
    chk("drain_end_count", 64'(count), 64'd0);
    chk("drain_end_sb", 64'(sb.size()), 64'd0);

    // Mixed traffic with random hold; pend_mask tracked against the scoreboard
    for (int c = 0; c < 200; c++) begin
      wr_hold = ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
      chk("rand_pend", 64'(pend_mask), 64'(model_pend()));
    end
    wr_hold = 1'b0;
    wait_drain("rand_drain");

    // Reset mid-operation with DEPTH-1 entries queued
    wr_hold = 1'b1;
    issue(1'b1, 4'd5, 64'd55, 1'b1, 4'd6, 64'd66);
    issue(1'b1, 4'd7, 64'd77, 1'b0, 4'd0, 64'd0);
    chk("three_count", 64'(count), 64'd3);
    chk("three_in_ready", 64'(in_ready), 64'd0);
    issue(1'b1, 4'd8, 64'd88, 1'b0, 4'd0, 64'd0);
    chk("three_single_ignored", 64'(count), 64'd3);
    rst_n = 1'b0;
    wr_hold = 1'b0;
    sb.delete();
    n0 = nwrites;
    tick();
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pend", 64'(pend_mask), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'hF);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    tick();
    chk("postrst_wr_en", 64'(wr_en), 64'd0);
    chk("postrst_nwrites", 64'(nwrites - n0), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
